// File: rtl/apb_i2c_regif_if.sv
// APB3 bus bundle between the system interconnect (master) and the I2C register front end (slave).
interface apb_i2c_regif_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_i2c_regif.sv
// Registered APB3 register front end for the I2C core: FIFO ports, CONFIG/TIMEOUT, STATUS, maskable IRQ.
// Optional APB_I2C_REGIF_PSLVERR_EN reports illegal accesses on PSLVERR; otherwise PSLVERR stays 0.
module apb_i2c_regif #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CFG_W  = 14,
  parameter int TO_W   = 14,
  parameter int RD_LAT = 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_i2c_regif_if.slave    apb,
  output logic [DATA_W-1:0] TX_WDATA,
  output logic              TX_WR_EN,
  input  logic              TX_FULL,
  input  logic              TX_EMPTY,
  input  logic [DATA_W-1:0] RX_RDATA,
  output logic              RX_RD_EN,
  input  logic              RX_EMPTY,
  input  logic              I2C_ERROR,
  output logic [CFG_W-1:0]  CFG_OUT,
  output logic [TO_W-1:0]   TIMEOUT_OUT,
  output logic              IRQ
);
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WAIT, S_RESP} state_e;

  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_CONFIG = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_TMOUT  = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] A_INTEN  = ADDR_W'(8'h14);
  localparam logic [ADDR_W-1:0] A_INTST  = ADDR_W'(8'h18);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic              tx_wr_en_q, tx_wr_en_d;
  logic [DATA_W-1:0] tx_wdata_q, tx_wdata_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [2:0]        int_en_q, int_en_d;
  logic [2:0]        int_stat_q, int_stat_d;
  logic              tx_empty_q, rx_empty_q, i2c_err_q;
  logic              irq_q, irq_d;

  logic [ADDR_W-1:0] addr;
  logic              is_tx, is_rx, is_cfg, is_to, is_stat, is_ien, is_ist;
  logic              acc_err, rx_read_ok, err_now, to_resp, commit;
  logic [DATA_W-1:0] rd_mux;
  logic [2:0]        int_set, w1c;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^apb.PADDR[1:0];

  // Address decode and access legality; PADDR/PWRITE are stable for the whole transfer.
  always_comb begin
    addr    = {apb.PADDR[ADDR_W-1:2], 2'b00};
    is_tx   = (addr == A_TXDATA);
    is_rx   = (addr == A_RXDATA);
    is_cfg  = (addr == A_CONFIG);
    is_to   = (addr == A_TMOUT);
    is_stat = (addr == A_STATUS);
    is_ien  = (addr == A_INTEN);
    is_ist  = (addr == A_INTST);
    acc_err = !(is_tx || is_rx || is_cfg || is_to || is_stat || is_ien || is_ist);
    if (is_tx && (!apb.PWRITE || TX_FULL)) acc_err = 1'b1;
    if (is_rx && (apb.PWRITE || RX_EMPTY)) acc_err = 1'b1;
    if (is_stat && apb.PWRITE)             acc_err = 1'b1;
    rx_read_ok = is_rx && !apb.PWRITE && !RX_EMPTY;
    rd_mux = '0;
    if (is_rx)        rd_mux = RX_RDATA;
    else if (is_cfg)  rd_mux[CFG_W-1:0] = cfg_q;
    else if (is_to)   rd_mux[TO_W-1:0]  = to_q;
    else if (is_stat) rd_mux[3:0] = {I2C_ERROR, TX_FULL, RX_EMPTY, TX_EMPTY};
    else if (is_ien)  rd_mux[2:0] = int_en_q;
    else if (is_ist)  rd_mux[2:0] = int_stat_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    prdata_d   = '0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    tx_wr_en_d = 1'b0;
    tx_wdata_d = tx_wdata_q;
    cfg_d      = cfg_q;
    to_d       = to_q;
    int_en_d   = int_en_q;
    w1c        = 3'b000;
    RX_RD_EN   = 1'b0;
    to_resp    = 1'b0;
    commit     = 1'b0;
    // Legality is frozen in DECODE: popping the last RX entry may raise RX_EMPTY during WAIT.
    err_now    = (state_q == S_DECODE) ? acc_err : err_q;

    case (state_q)
      S_IDLE: begin
        if (apb.PSEL && !apb.PENABLE) state_d = S_DECODE;
      end
      S_DECODE: begin
        err_d = acc_err;
        if (!apb.PSEL) begin
          state_d = S_IDLE;
        end else if (rx_read_ok) begin
          RX_RD_EN = 1'b1;
          cnt_d    = 3'(RD_LAT);
          if (RD_LAT == 0) to_resp = 1'b1;
          else             state_d = S_WAIT;
        end else begin
          to_resp = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (!apb.PSEL)          state_d = S_IDLE;
        else if (cnt_d == 3'd0) to_resp = 1'b1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        commit  = apb.PSEL && apb.PWRITE && !err_q;
        if (commit && is_cfg) cfg_d    = apb.PWDATA[CFG_W-1:0];
        if (commit && is_to)  to_d     = apb.PWDATA[TO_W-1:0];
        if (commit && is_ien) int_en_d = apb.PWDATA[2:0];
        if (commit && is_ist) w1c      = apb.PWDATA[2:0];
      end
      default: state_d = S_IDLE;
    endcase

    if (to_resp) begin
      state_d  = S_RESP;
      pready_d = 1'b1;
      if (!err_now && !apb.PWRITE) prdata_d = rd_mux;
      if (!err_now && apb.PWRITE && is_tx) begin
        tx_wr_en_d = 1'b1;
        tx_wdata_d = apb.PWDATA;
      end
`ifdef APB_I2C_REGIF_PSLVERR_EN
      pslverr_d = err_now;
`else
      pslverr_d = 1'b0;
`endif
    end

    int_set    = {I2C_ERROR & ~i2c_err_q, ~RX_EMPTY & rx_empty_q, TX_EMPTY & ~tx_empty_q};
    int_stat_d = (int_stat_q & ~w1c) | int_set;
    irq_d      = |(int_stat_q & int_en_q);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      err_q      <= 1'b0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      tx_wr_en_q <= 1'b0;
      tx_wdata_q <= '0;
      cfg_q      <= '0;
      to_q       <= '0;
      int_en_q   <= 3'b000;
      int_stat_q <= 3'b000;
      tx_empty_q <= 1'b0;
      rx_empty_q <= 1'b0;
      i2c_err_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      tx_wr_en_q <= tx_wr_en_d;
      tx_wdata_q <= tx_wdata_d;
      cfg_q      <= cfg_d;
      to_q       <= to_d;
      int_en_q   <= int_en_d;
      int_stat_q <= int_stat_d;
      tx_empty_q <= TX_EMPTY;
      rx_empty_q <= RX_EMPTY;
      i2c_err_q  <= I2C_ERROR;
      irq_q      <= irq_d;
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign TX_WR_EN    = tx_wr_en_q;
  assign TX_WDATA    = tx_wdata_q;
  assign CFG_OUT     = cfg_q;
  assign TIMEOUT_OUT = to_q;
  assign IRQ         = irq_q;
endmodule

// File: tb/tb_apb_i2c_regif.sv
// Directed-vector bench for apb_i2c_regif (RD_LAT=2) with a queue scoreboard on APB responses.
module tb_apb_i2c_regif;
`ifdef APB_I2C_REGIF_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        err;
    int          waits;
  } exp_t;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [31:0] TX_WDATA;
  logic        TX_WR_EN;
  logic        TX_FULL = 1'b0;
  logic        TX_EMPTY = 1'b0;
  logic [31:0] RX_RDATA = 32'hDEADBEEF;
  logic        RX_RD_EN;
  logic        RX_EMPTY = 1'b0;
  logic        I2C_ERROR = 1'b0;
  logic [13:0] CFG_OUT;
  logic [13:0] TIMEOUT_OUT;
  logic        IRQ;

  apb_i2c_regif_if #(.ADDR_W(8), .DATA_W(32)) apb ();

  apb_i2c_regif #(.DATA_W(32), .ADDR_W(8), .CFG_W(14), .TO_W(14), .RD_LAT(2)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(apb),
    .TX_WDATA(TX_WDATA), .TX_WR_EN(TX_WR_EN), .TX_FULL(TX_FULL), .TX_EMPTY(TX_EMPTY),
    .RX_RDATA(RX_RDATA), .RX_RD_EN(RX_RD_EN), .RX_EMPTY(RX_EMPTY), .I2C_ERROR(I2C_ERROR),
    .CFG_OUT(CFG_OUT), .TIMEOUT_OUT(TIMEOUT_OUT), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          tx_cnt = 0;
  int          rx_cnt = 0;
  logic [31:0] tx_last = '0;
  bit          seen;
  int          tx0, rx0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe counters sampled mid-cycle.
  initial begin
    forever begin
      @(negedge PCLK);
      if (TX_WR_EN === 1'b1) begin tx_cnt++; tx_last = TX_WDATA; end
      if (RX_RD_EN === 1'b1) rx_cnt++;
    end
  end

  // RX FIFO model: data valid exactly two cycles after the pop strobe, garbage otherwise.
  initial begin
    logic en_s, p0, p1;
    p0 = 1'b0; p1 = 1'b0;
    forever begin
      @(negedge PCLK);
      en_s = (RX_RD_EN === 1'b1);
      @(posedge PCLK); #1;
      p1 = p0; p0 = en_s;
      RX_RDATA = p1 ? 32'h0000005A : 32'hDEADBEEF;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input bit exp_err, input int exp_wait);
    exp_t e;
    bit   done;
    e.addr = addr; e.data = exp_rd; e.err = exp_err; e.waits = exp_wait;
    exp_q.push_back(e);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = addr; apb.PWDATA = wdata;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge PCLK);
      if (apb.PREADY === 1'b1) done = 1'b1;
    end
    check($sformatf("pready_timeout@%0h", addr), 32'(done), 32'd1);
    if (!done) void'(exp_q.pop_back());
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
    fork
      // Response monitor: counts wait states and scores each PREADY against the queue.
      begin
        int   wcnt;
        exp_t e;
        wcnt = 0;
        forever begin
          @(negedge PCLK);
          if (apb.PSEL && apb.PENABLE && apb.PREADY !== 1'b1) wcnt++;
          else if (!apb.PSEL) wcnt = 0;
          if (apb.PREADY === 1'b1) begin
            if (exp_q.size() == 0) begin
              vectors++; miscompares++;
              $display("FAIL unexpected_pready: got PREADY=1, expected no response pending");
            end else begin
              e = exp_q.pop_front();
              check($sformatf("prdata@%0h", e.addr), apb.PRDATA, e.data);
              check($sformatf("pslverr@%0h", e.addr), 32'(apb.PSLVERR), 32'(e.err));
              check($sformatf("waits@%0h", e.addr), 32'(wcnt), 32'(e.waits));
            end
            wcnt = 0;
          end
        end
      end
    join_none

    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready", 32'(apb.PREADY), 32'd0);
    check("rst_pslverr", 32'(apb.PSLVERR), 32'd0);
    check("rst_prdata", apb.PRDATA, 32'd0);
    check("rst_strobes", {30'd0, TX_WR_EN, RX_RD_EN}, 32'd0);
    check("rst_irq", 32'(IRQ), 32'd0);
    check("rst_cfg", 32'(CFG_OUT), 32'd0);
    check("rst_timeout", 32'(TIMEOUT_OUT), 32'd0);
    check("rst_txwdata", TX_WDATA, 32'd0);
    PRESETn = 1'b1;

    apb_xfer(0, 8'h08, 0, 32'h0, 0, 1);
    apb_xfer(0, 8'h0C, 0, 32'h0, 0, 1);
    apb_xfer(0, 8'h14, 0, 32'h0, 0, 1);
    apb_xfer(0, 8'h18, 0, 32'h0, 0, 1);

    apb_xfer(1, 8'h08, 32'hFFFFABCD, 32'h0, 0, 1);
    check("cfg_out", 32'(CFG_OUT), 32'h2BCD);
    apb_xfer(0, 8'h08, 0, 32'h00002BCD, 0, 1);
    apb_xfer(1, 8'h0C, 32'h00001234, 32'h0, 0, 1);
    check("timeout_out", 32'(TIMEOUT_OUT), 32'h1234);
    apb_xfer(0, 8'h0D, 0, 32'h00001234, 0, 1);

    tx0 = tx_cnt;
    apb_xfer(1, 8'h00, 32'h000000A5, 32'h0, 0, 1);
    check("tx_pulses", 32'(tx_cnt - tx0), 32'd1);
    check("tx_wdata", tx_last, 32'hA5);
    TX_FULL = 1'b1;
    tx0 = tx_cnt;
    apb_xfer(1, 8'h00, 32'h000000A5, 32'h0, ERR_EN, 1);
    check("tx_full_no_pulse", 32'(tx_cnt - tx0), 32'd0);
    apb_xfer(0, 8'h10, 0, 32'h4, 0, 1);
    TX_FULL = 1'b0;
    apb_xfer(0, 8'h00, 0, 32'h0, ERR_EN, 1);

    rx0 = rx_cnt;
    apb_xfer(0, 8'h04, 0, 32'h5A, 0, 3);
    check("rx_pulses", 32'(rx_cnt - rx0), 32'd1);

    apb_xfer(1, 8'h14, 32'h4, 32'h0, 0, 1);
    apb_xfer(0, 8'h14, 0, 32'h4, 0, 1);
    I2C_ERROR = 1'b1;
    @(posedge PCLK); #1;
    check("irq_not_yet", 32'(IRQ), 32'd0);
    @(posedge PCLK); #1;
    check("irq_set", 32'(IRQ), 32'd1);
    I2C_ERROR = 1'b0;
    apb_xfer(0, 8'h18, 0, 32'h4, 0, 1);

    seen = 1'b0;
    fork
      apb_xfer(1, 8'h18, 32'h4, 32'h0, 0, 1);
      begin
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge PCLK);
          if (apb.PREADY === 1'b1) begin I2C_ERROR = 1'b1; seen = 1'b1; end
        end
      end
    join
    @(posedge PCLK); #1;
    I2C_ERROR = 1'b0;
    @(posedge PCLK); #1;
    check("irq_set_wins", 32'(IRQ), 32'd1);
    apb_xfer(0, 8'h18, 0, 32'h4, 0, 1);

    apb_xfer(1, 8'h18, 32'h4, 32'h0, 0, 1);
    check("irq_hold_at_commit", 32'(IRQ), 32'd1);
    @(posedge PCLK); #1;
    check("irq_cleared", 32'(IRQ), 32'd0);
    apb_xfer(0, 8'h18, 0, 32'h0, 0, 1);

    RX_EMPTY = 1'b1;
    rx0 = rx_cnt;
    apb_xfer(0, 8'h04, 0, 32'h0, ERR_EN, 1);
    check("rx_empty_no_pop", 32'(rx_cnt - rx0), 32'd0);
    apb_xfer(0, 8'h20, 0, 32'h0, ERR_EN, 1);
    apb_xfer(1, 8'h10, 32'hF, 32'h0, ERR_EN, 1);
    apb_xfer(1, 8'h04, 32'h1, 32'h0, ERR_EN, 1);

    // Abandon a CONFIG write during DECODE: no commit, no response.
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 8'h08; apb.PWDATA = 32'h1111;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check("abort_cfg", 32'(CFG_OUT), 32'h2BCD);
    apb_xfer(0, 8'h08, 0, 32'h00002BCD, 0, 1);

    repeat (2) @(posedge PCLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
